soc_mem: RTL and testbench

- Memory-side block directly downstream of the core's memory-interface arbiter; consumes its word address, write data and byte write-enables, and returns read data.
- Contains a byte-writable on-chip RAM and a small MMIO region holding a UART transmitter with a TX FIFO and a programmable baud divider.
- Reads have a fixed one-cycle latency, matching the arbiter's fixed-latency assumption.

---
 rtl/soc_mem.sv | 157 +++++++++++++++
 tb/tb_soc_mem.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_mem.sv
// Memory-side slave: byte-writable RAM plus an MMIO UART transmitter (TX FIFO, baud divider).
// Reads return one cycle after the address is presented.
module soc_mem #(
  parameter int              M_WIDTH        = 32,
  parameter int              AW             = 30,
  parameter int              RAM_WORDS      = 1024,
  parameter logic [AW-1:0]   MMIO_BASE      = 30'h0800_0000,
  parameter int              FIFO_DEPTH     = 4,
  parameter logic [15:0]     BAUD_DIV_RESET = 16'd867,
  parameter string           INIT_FILE      = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        addr,
  input  logic [M_WIDTH-1:0]   wdata,
  input  logic [M_WIDTH/8-1:0] wes,
  output logic [M_WIDTH-1:0]   rdata,
  output logic                 uart_tx,
  output logic                 tx_idle
);
  localparam int NB  = M_WIDTH / 8;
  localparam int RAW = $clog2(RAM_WORDS);
  localparam int PW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

  logic [M_WIDTH-1:0] mem [RAM_WORDS];
  logic [M_WIDTH-1:0] ram_q, mmio_q, mmio_d;
  logic               ram_sel_q;
  logic [15:0]        baud_q;
  logic               ovf_q;
  logic [7:0]         fifo_q [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PW:0]        count_q;
  tx_state_e          state_q;
  logic [15:0]        cnt_q;
  logic [2:0]         bit_q;
  logic [7:0]         shift_q;
  logic               tx_q;

  logic ram_sel, txd_sel, sts_sel, baud_sel;
  logic fifo_full, fifo_empty, push_req, push_ok, pop;
  logic [RAW-1:0] ram_idx;

  assign ram_sel    = addr < AW'(RAM_WORDS);
  assign txd_sel    = addr == MMIO_BASE;
  assign sts_sel    = addr == MMIO_BASE + AW'(1);
  assign baud_sel   = addr == MMIO_BASE + AW'(2);
  assign ram_idx    = addr[RAW-1:0];
  assign fifo_full  = count_q == (PW+1)'(FIFO_DEPTH);
  assign fifo_empty = count_q == '0;
  assign push_req   = txd_sel && wes[0];
  // The FSM pops when idle, or at the very end of a stop bit so frames run back to back.
  assign pop        = !fifo_empty && ((state_q == S_IDLE) || (state_q == S_STOP && cnt_q == '0));
  assign push_ok    = push_req && (!fifo_full || pop);

  assign rdata   = ram_sel_q ? ram_q : mmio_q;
  assign uart_tx = tx_q;
  assign tx_idle = fifo_empty && (state_q == S_IDLE);

  // RAM array has no reset; the read port sees the pre-write word (read-before-write).
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (ram_sel && wes[i]) mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    ram_q <= mem[ram_idx];
  end

  always_comb begin
    mmio_d = '0;
    if (sts_sel)       mmio_d[3:0]  = {ovf_q, state_q != S_IDLE, fifo_empty, fifo_full};
    else if (baud_sel) mmio_d[15:0] = baud_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_sel_q <= 1'b0;
      mmio_q    <= '0;
      baud_q    <= BAUD_DIV_RESET;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      ram_sel_q <= ram_sel;
      mmio_q    <= mmio_d;
      if (baud_sel && wes[0]) baud_q[7:0]  <= wdata[7:0];
      if (baud_sel && wes[1]) baud_q[15:8] <= wdata[15:8];
      if (push_req && !push_ok)                  ovf_q <= 1'b1;
      else if (sts_sel && wes[0] && wdata[3])    ovf_q <= 1'b0;
      if (push_ok) begin
        fifo_q[wr_ptr_q] <= wdata[7:0];
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PW+1)'(push_ok) - (PW+1)'(pop);

      // Counter reloads from baud_q only at bit boundaries, so BAUD writes never stretch a bit.
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q <= fifo_q[rd_ptr_q];
            cnt_q   <= baud_q;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == '0) begin
            cnt_q   <= baud_q;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == '0) begin
            cnt_q <= baud_q;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
              bit_q   <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == '0) begin
            if (pop) begin
              shift_q <= fifo_q[rd_ptr_q];
              cnt_q   <= baud_q;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_soc_mem.sv
// Bench for soc_mem: RAM/MMIO reads checked through an expected-read queue, UART frames
// decoded from the serial line and compared against an expected-byte queue.
module tb_soc_mem;
  localparam int          RAM_WORDS  = 1024;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [29:0] MMIO       = 30'h0800_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wes;
  logic [31:0] rdata;
  logic        uart_tx, tx_idle;

  soc_mem dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wes(wes),
    .rdata(rdata), .uart_tx(uart_tx), .tx_idle(tx_idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: RAM words, BAUD, OVF and the bytes expected on the line.
  logic [31:0] exp_q[$];
  logic [7:0]  tx_exp_q[$];
  logic [31:0] ram_m [RAM_WORDS];
  logic [15:0] baud_m  = 16'd867;
  bit          ovf_m   = 1'b0;
  int          tx_cap  = 1000;
  int          bit_cyc = 868;

  bit issue_rd = 1'b0;
  bit pend     = 1'b0;
  int frames_rx = 0;
  int contig_rx = 0;
  bit mon_busy  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [29:0] a);
    if (a < 30'(RAM_WORDS)) return ram_m[a];
    if (a == MMIO + 30'd1)  return {28'd0, ovf_m, 3'b010};
    if (a == MMIO + 30'd2)  return {16'd0, baud_m};
    return 32'd0;
  endfunction

  function automatic void model_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] w);
    if (a < 30'(RAM_WORDS)) begin
      for (int i = 0; i < 4; i++) begin
        if (w[i]) ram_m[a][8*i +: 8] = d[8*i +: 8];
      end
    end else if (a == MMIO && w[0]) begin
      if (tx_cap > 0) begin
        tx_exp_q.push_back(d[7:0]);
        tx_cap--;
      end else begin
        ovf_m = 1'b1;
      end
    end else if (a == MMIO + 30'd1 && w[0] && d[3]) begin
      ovf_m = 1'b0;
    end else if (a == MMIO + 30'd2) begin
      if (w[0]) baud_m[7:0]  = d[7:0];
      if (w[1]) baud_m[15:8] = d[15:8];
      bit_cyc = int'(baud_m) + 1;
    end
  endfunction

  task automatic drive(input logic [29:0] a, input logic [31:0] d, input logic [3:0] w, input bit rd);
    @(negedge clk);
    addr = a; wdata = d; wes = w; issue_rd = rd;
    if (rd) exp_q.push_back(model_read(a));
    model_write(a, d, w);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(MMIO + 30'd7, 32'd0, 4'h0, 1'b0);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    repeat (3) @(negedge clk);
    while (!(tx_idle === 1'b1 && !mon_busy) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= max_cyc) begin
      errors++;
      $display("FAIL tx_idle_timeout: still busy after %0d cycles, required idle", n);
    end
  endtask

  // Read scoreboard: a read issued before a rising edge is due on rdata after it.
  always @(posedge clk) pend <= issue_rd;
  always @(negedge clk) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got %h expected no read", rdata);
      end else begin
        check("rdata", rdata, exp_q.pop_front());
      end
    end
  end

  task automatic rx_frame();
    logic [9:0] fr;
    logic       lvl;
    bit         hold_ok = 1'b1;
    bit         abort   = 1'b0;
    fr = '0; lvl = 1'b0;
    mon_busy = 1'b1;
    for (int b = 0; b < 10 && !abort; b++) begin
      for (int c = 0; c < bit_cyc && !abort; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (!rst)          abort = 1'b1;
        else if (c == 0)   lvl = uart_tx;
        else if (uart_tx !== lvl) hold_ok = 1'b0;
      end
      fr[b] = lvl;
    end
    if (!abort) begin
      frames_rx++;
      check("uart_hold", 32'(hold_ok), 32'd1);
      if (tx_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL uart_unexpected: got frame %b expected none", fr);
      end else begin
        logic [7:0] e;
        e = tx_exp_q.pop_front();
        check("uart_frame", 32'(fr), 32'({1'b1, e, 1'b0}));
      end
    end
    mon_busy = 1'b0;
  endtask

  // Line monitor: a low level on an idle line starts a frame; back-to-back frames counted.
  initial begin
    bit ended = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && uart_tx === 1'b0) begin
        if (ended) contig_rx++;
        rx_frame();
        ended = 1'b1;
      end else begin
        ended = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int f0, c0;
    addr = MMIO + 30'd7; wdata = '0; wes = '0;

    // Reset: read port, line and idle flag held at their reset values.
    repeat (3) begin
      @(negedge clk);
      addr = 30'd5; issue_rd = 1'b1;
      exp_q.push_back(32'd0);
    end
    @(negedge clk);
    addr = MMIO + 30'd7; issue_rd = 1'b0;
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_tx_idle", 32'(tx_idle), 32'd1);
    #2 rst = 1'b1;

    for (int i = 0; i < 16; i++) drive(30'(i), $urandom, 4'hF, 1'b0);

    drive(30'd5, 32'hDEADBEEF, 4'hF, 1'b0);
    drive(30'd5, 32'd0, 4'h0, 1'b1);
    drive(30'd5, 32'h000000AA, 4'b0001, 1'b0);
    drive(30'd5, 32'd0, 4'h0, 1'b1);
    drive(30'd5, 32'h11223344, 4'hF, 1'b1);
    drive(30'd5, 32'd0, 4'h0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      logic [29:0] a;
      a = 30'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = MMIO + 30'd2;
      drive(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    drive(30'(RAM_WORDS + 1), $urandom, 4'hF, 1'b0);
    drive(30'd1, 32'd0, 4'h0, 1'b1);
    drive(MMIO + 30'd5, 32'd0, 4'h0, 1'b1);
    drive(30'(RAM_WORDS + 1), 32'd0, 4'h0, 1'b1);
    drive(MMIO, 32'd0, 4'h0, 1'b1);
    idle(2);

    // Single frames at four cycles per bit.
    drive(MMIO + 30'd2, 32'd3, 4'b0011, 1'b0);
    drive(MMIO + 30'd2, 32'd0, 4'h0, 1'b1);
    drive(MMIO, 32'h000000A5, 4'b0001, 1'b0);
    idle(1);
    wait_idle(200);
    check("idle_after_stop", 32'(tx_idle), 32'd1);
    drive(MMIO + 30'd1, 32'd0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(MMIO, $urandom, 4'($urandom_range(0, 15)) | 4'h1, 1'b0);
      idle(1);
      wait_idle(200);
    end

    // Burst of six at one cycle per bit: one byte leaves the FIFO at once, four queue, one drops.
    drive(MMIO + 30'd2, 32'd0, 4'b0011, 1'b0);
    f0 = frames_rx; c0 = contig_rx;
    tx_cap = FIFO_DEPTH + 1;
    for (int i = 0; i < 6; i++) drive(MMIO, $urandom, 4'h1, 1'b0);
    tx_cap = 1000;
    idle(1);
    wait_idle(400);
    check("burst_frames", 32'(frames_rx - f0), 32'd5);
    check("burst_contig", 32'(contig_rx - c0), 32'd4);
    drive(MMIO + 30'd1, 32'd0, 4'h0, 1'b1);
    drive(MMIO + 30'd1, 32'h8, 4'h1, 1'b0);
    drive(MMIO + 30'd1, 32'd0, 4'h0, 1'b1);
    idle(2);

    // Reset in the middle of an all-zero data phase with more bytes queued.
    drive(MMIO + 30'd2, 32'd3, 4'b0011, 1'b0);
    drive(MMIO, 32'h00, 4'h1, 1'b0);
    drive(MMIO, $urandom, 4'h1, 1'b0);
    drive(MMIO, $urandom, 4'h1, 1'b0);
    idle(12);
    @(posedge clk);
    #1 check("pre_rst_data", 32'(uart_tx), 32'd0);
    #1 rst = 1'b0;
    #1;
    check("midrst_uart_tx", 32'(uart_tx), 32'd1);
    check("midrst_tx_idle", 32'(tx_idle), 32'd1);
    tx_exp_q.delete();
    ovf_m = 1'b0; baud_m = 16'd867; bit_cyc = 868;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    idle(3);
    check("post_rst_idle", 32'(tx_idle), 32'd1);
    drive(MMIO + 30'd1, 32'd0, 4'h0, 1'b1);
    drive(MMIO + 30'd2, 32'd0, 4'h0, 1'b1);
    idle(2);

    check("rd_queue_drained", 32'(exp_q.size()), 32'd0);
    check("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
